irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Peripheral interrupt controller. It is the receiving end of the level interrupt lines driven by bus-slave peripherals, e.g. the timer's int_sig_o.
- Latches requests per source, gates each source while it is in service, and selects the winner by fixed priority.
- Presents a single request plus ID to the core's interrupt/CLINT logic, with an ack (claim) handshake from the core and a software complete write over the peripheral bus.
- Sits on the same 32-bit peripheral bus as the timer.

Parameters:
- NUM_IRQ, 8, number of interrupt sources (legal 1..31). Source k has ID k+1; ID 0 means "none".

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous reset, active low
- irq_i  in  NUM_IRQ  level interrupt lines from peripherals, bit k = source k
- data_i  in  32  bus write data
- addr_i  in  32  bus address; only addr_i[3:0] decoded
- we_i  in  1  bus write enable
- data_o  out  32  bus read data, combinational
- int_req_o  out  1  interrupt request to core
- int_id_o  out  5  ID of the requested/active source
- int_ack_i  in  1  one-cycle pulse from core: trap taken, source claimed

Behaviour:
- Interface: reset rstn, synchronous, active-low; clock clk. All state updates on posedge clk.
- Reset values: enable=0, pending=0, in_service=0, active_id=0, state=IDLE, int_req_o=0, int_id_o=0. data_o=0 while rstn low.
- Register map (offset on addr_i[3:0]):
  - 0x0 ENABLE: rw, bits [NUM_IRQ-1:0], upper bits read 0.
  - 0x4 PENDING: ro, writes ignored.
  - 0x8 CLAIM/COMPLETE: read returns active_id in SERVICE, else 0. Write = complete request.
  - 0xC STATUS: ro, [1:0]=state (IDLE=0, REQ=1, SERVICE=2), [12:8]=active_id.
  - Other offsets: read 0, write ignored.
- Gateway (per source k):
  - pending[k] is set at a clock edge when irq_i[k]=1 and in_service[k]=0.
  - pending[k] is cleared only by a claim. Deasserting irq_i does not clear a set pending bit.
  - Sources are not synchronized; irq_i is assumed to come from the clk domain.
- Selection: eligible = pending & enable. Winner = lowest set index, ID = index+1.
- FSM:
  - IDLE: int_req_o=0, int_id_o=0. If eligible != 0, latch active_id=winner ID and go to REQ.
  - REQ: int_req_o=1, int_id_o=active_id, held stable. A higher-priority source arriving in REQ does not change the ID.
    - int_ack_i=1: clear pending[active_id-1], set in_service[active_id-1], go to SERVICE.
    - Else, if enable[active_id-1] becomes 0 (including via an ENABLE write this cycle): go to IDLE, pending kept, active_id=0.
  - SERVICE: int_req_o=0, int_id_o=active_id.
    - Write to 0x8 with data_i[4:0]==active_id: clear in_service, active_id=0, go to IDLE.
    - Mismatched or out-of-range IDs are ignored.
  - int_ack_i outside REQ is ignored. A complete write outside SERVICE is ignored.
- Latency:
  - irq_i high sampled at edge k gives pending=1 after edge k.
  - State goes to REQ and int_req_o=1 after edge k+1.
  - After a complete at edge c, a re-request can go to REQ at edge c+2 at the earliest.
- Level re-trigger: if irq_i[k] is still high at complete (software did not clear the peripheral), pending[k] sets again on the next edge and the source re-requests.
- Same-cycle pending set and claim of the same source is impossible: in_service is set by the claim and blocks the set.
- Reset mid-operation (REQ or SERVICE): everything returns to reset values on the next edge; int_req_o drops.

Test Plan:
- Single source: NUM_IRQ=8, ENABLE=0x01. Pulse irq_i[0] for 1 cycle at edge 5 -> PENDING=0x01 after edge 5; int_req_o=1, int_id_o=1 after edge 6. Ack -> PENDING=0, read 0x8=1. Write 1 to 0x8 -> IDLE, int_req_o stays 0.
- Priority: ENABLE=0xFF, irq_i=0x84 in the same cycle -> int_id_o=3. After ack and complete of ID 3 (irq_i[2] low), next request int_id_o=8.
- ID freeze and disable: in REQ with ID 8, raise irq_i[0] -> int_id_o remains 8. Then write ENABLE=0x7F -> IDLE next edge, PENDING keeps bit 7. Next request has ID 1.
- Gating and level re-trigger: hold irq_i[1]=1 through claim -> PENDING bit1=0 during SERVICE. Write wrong ID 5 to 0x8 -> still SERVICE. Write 2 -> PENDING bit1=1 one edge later, int_req_o=1 the edge after.
- Stray inputs: int_ack_i in IDLE and complete write in REQ -> no state, pending or in_service change. Write to 0x4 -> PENDING unchanged.
- Reset during SERVICE: drive rstn=0 for one edge -> int_req_o=0, STATUS=0, ENABLE=0, PENDING=0. data_o=0 while rstn low.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - peripheral bus and core interrupt handshake bundle for irq_ctrl
//
// Purpose: groups the 32-bit peripheral bus signals and the core-side
// request/ack handshake of the interrupt controller.
// Signals:
//   data_i    32  bus write data           (master -> slave)
//   addr_i    32  bus address              (master -> slave)
//   we_i       1  bus write enable         (master -> slave)
//   data_o    32  bus read data            (slave -> master)
//   int_req_o  1  interrupt request        (slave -> master)
//   int_id_o   5  requested/active ID      (slave -> master)
//   int_ack_i  1  claim pulse from core    (master -> slave)
interface irq_ctrl_if;
  logic [31:0] data_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic [31:0] data_o;
  logic        int_req_o;
  logic [4:0]  int_id_o;
  logic        int_ack_i;

  modport slave (
    input  data_i, addr_i, we_i, int_ack_i,
    output data_o, int_req_o, int_id_o
  );

  modport master (
    output data_i, addr_i, we_i, int_ack_i,
    input  data_o, int_req_o, int_id_o
  );
endinterface

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - fixed-priority peripheral interrupt controller with claim/complete
//
// Purpose: latches level interrupt requests per source, gates sources while
// in service, picks the lowest-index eligible source and presents it to the
// core; the core claims with int_ack_i, software completes via register 0x8.
// Ports:
//   clk    1        clock, all state on posedge
//   rstn   1        synchronous reset, active low
//   irq_i  NUM_IRQ  level interrupt lines, bit k = source k (ID k+1)
//   bus    slave    data_i/addr_i/we_i/data_o bus, int_req_o/int_id_o/int_ack_i
// Registers (addr_i[3:0]): 0x0 ENABLE rw, 0x4 PENDING ro,
//   0x8 CLAIM(read)/COMPLETE(write), 0xC STATUS {active_id[12:8], state[1:0]}.
module irq_ctrl #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_IRQ-1:0] irq_i,
  irq_ctrl_if.slave          bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] enable;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] in_service;
  logic [4:0]         active_id;
  logic               int_req;
  logic [4:0]         int_id;

  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] act_mask;
  logic [NUM_IRQ-1:0] claim_mask;
  logic [NUM_IRQ-1:0] done_mask;
  logic [NUM_IRQ-1:0] enable_next;
  logic [4:0]         win_id;
  logic               wr_enable;
  logic               wr_complete;
  logic               claim;
  logic               complete_ok;
  logic               drop_req;
  logic [31:0]        enable_rd;
  logic [31:0]        pending_rd;

  assign wr_enable   = bus.we_i && (bus.addr_i[3:0] == 4'h0);
  assign wr_complete = bus.we_i && (bus.addr_i[3:0] == 4'h8);
  assign eligible    = pending & enable;
  assign enable_next = wr_enable ? bus.data_i[NUM_IRQ-1:0] : enable;

  // Lowest index wins; one-hot mask of the source behind active_id.
  always_comb begin
    win_id   = 5'd0;
    act_mask = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (eligible[k]) win_id = 5'(k + 1);
    end
    for (int k = 0; k < NUM_IRQ; k++) begin
      act_mask[k] = (active_id == 5'(k + 1));
    end
  end

  assign claim       = (state == REQ) && bus.int_ack_i;
  assign complete_ok = (state == SERVICE) && wr_complete && (bus.data_i[4:0] == active_id);
  assign claim_mask  = claim ? act_mask : '0;
  assign done_mask   = complete_ok ? act_mask : '0;
  // An ENABLE write landing in the same cycle already withdraws the request.
  assign drop_req    = (state == REQ) && !bus.int_ack_i && ((enable_next & act_mask) == '0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      enable     <= '0;
      pending    <= '0;
      in_service <= '0;
      active_id  <= 5'd0;
      int_req    <= 1'b0;
      int_id     <= 5'd0;
    end else begin
      enable     <= enable_next;
      // The old in_service still blocks on the complete edge, so a level
      // re-trigger sets pending one edge after the complete. The claim mask
      // blocks the set on the claim edge itself.
      pending    <= (pending | (irq_i & ~(in_service | claim_mask))) & ~claim_mask;
      in_service <= (in_service | claim_mask) & ~done_mask;
      case (state)
        IDLE: begin
          if (eligible != '0) begin
            state     <= REQ;
            active_id <= win_id;
            int_req   <= 1'b1;
            int_id    <= win_id;
          end
        end
        REQ: begin
          if (claim) begin
            state   <= SERVICE;
            int_req <= 1'b0;
          end else if (drop_req) begin
            state     <= IDLE;
            active_id <= 5'd0;
            int_req   <= 1'b0;
            int_id    <= 5'd0;
          end
        end
        SERVICE: begin
          if (complete_ok) begin
            state     <= IDLE;
            active_id <= 5'd0;
            int_id    <= 5'd0;
          end
        end
        default: begin
          state     <= IDLE;
          active_id <= 5'd0;
          int_req   <= 1'b0;
          int_id    <= 5'd0;
        end
      endcase
    end
  end

  always_comb begin
    enable_rd  = '0;
    pending_rd = '0;
    enable_rd[NUM_IRQ-1:0]  = enable;
    pending_rd[NUM_IRQ-1:0] = pending;
  end

  always_comb begin
    bus.data_o = 32'd0;
    if (rstn) begin
      case (bus.addr_i[3:0])
        4'h0:    bus.data_o = enable_rd;
        4'h4:    bus.data_o = pending_rd;
        4'h8:    bus.data_o = (state == SERVICE) ? {27'd0, active_id} : 32'd0;
        4'hC:    bus.data_o = {19'd0, active_id, 6'd0, state};
        default: bus.data_o = 32'd0;
      endcase
    end
  end

  assign bus.int_req_o = int_req;
  assign bus.int_id_o  = int_id;

  logic unused_bits;
  assign unused_bits = ^{bus.addr_i[31:4], bus.data_i[31:5]};

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed scoreboard bench for irq_ctrl
module tb_irq_ctrl;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] irq = 8'd0;

  irq_ctrl_if bus_if ();

  irq_ctrl #(.NUM_IRQ(8)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .irq_i (irq),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  localparam logic [3:0] A_EN = 4'h0, A_PEND = 4'h4, A_CLAIM = 4'h8, A_STAT = 4'hC;

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %h with no expectation queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    bus_if.addr_i = {28'd0, a};
    bus_if.we_i   = 1'b0;
    #1;
    d = bus_if.data_o;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus_if.addr_i = {28'd0, a};
    bus_if.data_i = d;
    bus_if.we_i   = 1'b1;
    tick();
    bus_if.we_i   = 1'b0;
  endtask

  task automatic ack();
    bus_if.int_ack_i = 1'b1;
    tick();
    bus_if.int_ack_i = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    push(tag, exp);
    rd(a, d);
    check(d);
  endtask

  task automatic chk_out(input string tag, input logic req, input logic [4:0] id);
    push({tag, "_req"}, {31'd0, req});
    push({tag, "_id"}, {27'd0, id});
    check({31'd0, bus_if.int_req_o});
    check({27'd0, bus_if.int_id_o});
  endtask

  initial begin
    bus_if.data_i    = 32'd0;
    bus_if.addr_i    = 32'd0;
    bus_if.we_i      = 1'b0;
    bus_if.int_ack_i = 1'b0;

    // Reset
    tick(); tick();
    chk_out("rst", 1'b0, 5'd0);
    chk_rd("rst_data_low", A_STAT, 32'd0);
    rstn = 1'b1;
    chk_rd("rst_status", A_STAT, 32'd0);
    chk_rd("rst_enable", A_EN, 32'd0);

    // Single source
    wr(A_EN, 32'h0000_0001);
    chk_rd("t1_enable", A_EN, 32'h1);
    irq = 8'h01;
    tick();
    irq = 8'h00;
    chk_rd("t1_pend_set", A_PEND, 32'h1);
    chk_out("t1_pre_req", 1'b0, 5'd0);
    tick();
    chk_out("t1_req", 1'b1, 5'd1);
    chk_rd("t1_stat_req", A_STAT, 32'h101);
    ack();
    chk_rd("t1_pend_clr", A_PEND, 32'h0);
    chk_rd("t1_claim", A_CLAIM, 32'h1);
    chk_out("t1_service", 1'b0, 5'd1);
    wr(A_CLAIM, 32'd1);
    chk_rd("t1_idle", A_STAT, 32'h0);
    tick();
    chk_out("t1_no_rereq", 1'b0, 5'd0);

    // Priority
    wr(A_EN, 32'h0000_00FF);
    irq = 8'h84;
    tick();
    irq = 8'h00;
    tick();
    chk_out("t2_prio", 1'b1, 5'd3);
    ack();
    chk_rd("t2_pend_after_ack", A_PEND, 32'h80);
    wr(A_CLAIM, 32'd3);
    tick();
    chk_out("t2_next", 1'b1, 5'd8);

    // ID freeze and disable
    irq = 8'h01;
    tick();
    irq = 8'h00;
    chk_out("t3_freeze", 1'b1, 5'd8);
    wr(A_EN, 32'h0000_007F);
    chk_out("t3_drop", 1'b0, 5'd0);
    chk_rd("t3_stat_idle", A_STAT, 32'h0);
    chk_rd("t3_pend_kept", A_PEND, 32'h81);
    tick();
    chk_out("t3_next", 1'b1, 5'd1);

    // Stray complete in REQ, then normal claim/complete
    wr(A_CLAIM, 32'd1);
    chk_rd("t5_cpl_in_req", A_STAT, 32'h101);
    ack();
    wr(A_CLAIM, 32'd1);
    chk_rd("t3_done", A_STAT, 32'h0);

    // Gating and level re-trigger
    wr(A_EN, 32'h0000_0002);
    irq = 8'h02;
    tick();
    tick();
    chk_out("t4_req", 1'b1, 5'd2);
    ack();
    chk_rd("t4_pend_gated", A_PEND, 32'h80);
    chk_rd("t4_stat_svc", A_STAT, 32'h202);
    tick();
    chk_rd("t4_pend_still_gated", A_PEND, 32'h80);
    wr(A_CLAIM, 32'd5);
    chk_rd("t4_wrong_id", A_STAT, 32'h202);
    wr(A_CLAIM, 32'd2);
    chk_rd("t4_cpl_idle", A_STAT, 32'h0);
    chk_rd("t4_pend_cpl_edge", A_PEND, 32'h80);
    tick();
    chk_rd("t4_retrig_pend", A_PEND, 32'h82);
    chk_out("t4_retrig_wait", 1'b0, 5'd0);
    tick();
    irq = 8'h00;
    chk_out("t4_retrig_req", 1'b1, 5'd2);
    ack();
    wr(A_CLAIM, 32'd2);

    // Stray inputs in IDLE
    ack();
    chk_rd("t5_ack_idle_stat", A_STAT, 32'h0);
    chk_rd("t5_ack_idle_pend", A_PEND, 32'h80);
    wr(A_PEND, 32'h0000_00FF);
    chk_rd("t5_pend_ro", A_PEND, 32'h80);
    chk_out("t5_idle", 1'b0, 5'd0);

    // Reset during SERVICE
    irq = 8'h02;
    tick();
    irq = 8'h00;
    tick();
    ack();
    chk_rd("t6_svc", A_STAT, 32'h202);
    rstn = 1'b0;
    chk_rd("t6_data_low", A_STAT, 32'd0);
    tick();
    chk_out("t6_rst", 1'b0, 5'd0);
    chk_rd("t6_data_low_en", A_EN, 32'd0);
    rstn = 1'b1;
    chk_rd("t6_stat", A_STAT, 32'h0);
    chk_rd("t6_en", A_EN, 32'h0);
    chk_rd("t6_pend", A_PEND, 32'h0);
    tick();
    chk_out("t6_quiet", 1'b0, 5'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
